// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory request handshake and IF/ID register.
// Define IFETCH_BUF_EN to keep fetching during a stall through a one-entry buffer, so no bubble follows the stall.
module ifetch_stage #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               Clock,
  input  logic               Reset_,
  input  logic               Stall,
  input  logic               BranchTaken,
  input  logic [ADDR_W-1:0]  BranchTarget,
  output logic               IMemReq,
  output logic [ADDR_W-1:0]  IMemAddr,
  input  logic               IMemReady,
  input  logic [INSTR_W-1:0] IMemData,
  output logic [INSTR_W-1:0] Instr,
  output logic [ADDR_W-1:0]  PC4_ID,
  output logic               InstrValid,
  output logic               IFLUSH
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD} fetch_state_e;

  localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

  fetch_state_e state, next_state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic load_fetch;
  logic load_bubble;
  logic pc_advance;
`ifdef IFETCH_BUF_EN
  logic buf_capture;
  logic buf_release;
  logic [INSTR_W-1:0] buf_instr;
  logic [ADDR_W-1:0]  buf_pc4;
`endif

  assign pc_plus4 = pc + FOUR;
  assign IMemAddr = pc;

  always_ff @(posedge Clock or negedge Reset_) begin
    if (!Reset_) state <= S_BOOT;
    else         state <= next_state;
  end

  always_comb begin
    next_state  = state;
    IMemReq     = 1'b0;
    load_fetch  = 1'b0;
    load_bubble = 1'b0;
    pc_advance  = 1'b0;
`ifdef IFETCH_BUF_EN
    buf_capture = 1'b0;
    buf_release = 1'b0;
`endif
    unique case (state)
      S_BOOT: next_state = S_FETCH;
      S_FETCH: begin
`ifdef IFETCH_BUF_EN
        IMemReq = 1'b1;
        if (Stall && IMemReady) begin
          buf_capture = 1'b1;
          pc_advance  = 1'b1;
          next_state  = S_HOLD;
        end
`else
        IMemReq = !Stall;
`endif
        if (!Stall) begin
          if (IMemReady) begin
            load_fetch = 1'b1;
            pc_advance = 1'b1;
          end else begin
            load_bubble = 1'b1;
          end
        end
      end
      S_HOLD: begin
`ifdef IFETCH_BUF_EN
        if (!Stall) begin
          buf_release = 1'b1;
          next_state  = S_FETCH;
        end
`else
        next_state = S_FETCH;
`endif
      end
      default: next_state = S_BOOT;
    endcase
    // A redirect cancels everything in flight, including a pending buffer load.
    if (BranchTaken) begin
      next_state  = S_FETCH;
      load_fetch  = 1'b0;
      load_bubble = 1'b0;
      pc_advance  = 1'b0;
`ifdef IFETCH_BUF_EN
      buf_capture = 1'b0;
      buf_release = 1'b0;
`endif
    end
  end

  always_ff @(posedge Clock or negedge Reset_) begin
    if (!Reset_) begin
      pc         <= RESET_PC;
      Instr      <= '0;
      PC4_ID     <= '0;
      InstrValid <= 1'b0;
      IFLUSH     <= 1'b0;
    end else if (BranchTaken) begin
      pc         <= BranchTarget;
      Instr      <= '0;
      PC4_ID     <= '0;
      InstrValid <= 1'b0;
      IFLUSH     <= 1'b1;
    end else begin
      IFLUSH <= 1'b0;
      if (pc_advance) pc <= pc_plus4;
      if (load_fetch) begin
        Instr      <= IMemData;
        PC4_ID     <= pc_plus4;
        InstrValid <= 1'b1;
      end else if (load_bubble) begin
        Instr      <= '0;
        InstrValid <= 1'b0;
      end
`ifdef IFETCH_BUF_EN
      else if (buf_release) begin
        Instr      <= buf_instr;
        PC4_ID     <= buf_pc4;
        InstrValid <= 1'b1;
      end
`endif
    end
  end

`ifdef IFETCH_BUF_EN
  always_ff @(posedge Clock or negedge Reset_) begin
    if (!Reset_) begin
      buf_instr <= '0;
      buf_pc4   <= '0;
    end else if (buf_capture) begin
      buf_instr <= IMemData;
      buf_pc4   <= pc_plus4;
    end
  end
`endif

endmodule
